// File: rtl/resv_pkg.sv
// Shared definitions for the reservation station: opcodes, default widths
// and the entry layout at the default widths.
package resv_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 6;
  localparam int OP_W_DEF   = 2;

  localparam logic [OP_W_DEF-1:0] OP_LW  = 2'b00;
  localparam logic [OP_W_DEF-1:0] OP_SW  = 2'b01;
  localparam logic [OP_W_DEF-1:0] OP_ADD = 2'b10;
  localparam logic [OP_W_DEF-1:0] OP_MUL = 2'b11;

  // One source operand: ready flag, captured value, producer tag
  typedef struct packed {
    logic                  rdy;
    logic [DATA_W_DEF-1:0] val;
    logic [TAG_W_DEF-1:0]  tag;
  } src_t;

  // One station entry
  typedef struct packed {
    logic                 busy;
    logic [OP_W_DEF-1:0]  op;
    logic [TAG_W_DEF-1:0] dest;
    src_t                 s1;
    src_t                 s2;
  } entry_t;

endpackage

// File: rtl/resv_if.sv
// Allocation, CDB, dispatch and status signals of the reservation station.
// master = issue/CDB/functional-unit side, slave = the station itself.
interface resv_if
  import resv_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int OP_W   = OP_W_DEF
);
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [OP_W-1:0]            alloc_op;
  logic [TAG_W-1:0]           alloc_dest;
  logic                       src1_rdy;
  logic                       src2_rdy;
  logic [DATA_W-1:0]          src1_val;
  logic [DATA_W-1:0]          src2_val;
  logic [TAG_W-1:0]           src1_tag;
  logic [TAG_W-1:0]           src2_tag;
  logic                       cdb_valid;
  logic [TAG_W-1:0]           cdb_tag;
  logic [DATA_W-1:0]          cdb_data;
  logic                       disp_valid;
  logic                       disp_ready;
  logic [OP_W-1:0]            disp_op;
  logic [DATA_W-1:0]          disp_a;
  logic [DATA_W-1:0]          disp_b;
  logic [TAG_W-1:0]           disp_dest;
  logic                       flush;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output alloc_valid, alloc_op, alloc_dest, src1_rdy, src2_rdy,
           src1_val, src2_val, src1_tag, src2_tag,
           cdb_valid, cdb_tag, cdb_data, disp_ready, flush,
    input  alloc_ready, disp_valid, disp_op, disp_a, disp_b, disp_dest, count
  );

  modport slave (
    input  alloc_valid, alloc_op, alloc_dest, src1_rdy, src2_rdy,
           src1_val, src2_val, src1_tag, src2_tag,
           cdb_valid, cdb_tag, cdb_data, disp_ready, flush,
    output alloc_ready, disp_valid, disp_op, disp_a, disp_b, disp_dest, count
  );

endinterface

// File: rtl/resv_select.sv
// Ready-entry picker. Default: lowest-index request wins.
// With RS_AGE_ORDER_EN defined: the request with the smallest age rank
// (oldest allocation) wins; ranks of busy entries are unique.
module resv_select
  import resv_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            i_req,
`ifdef RS_AGE_ORDER_EN
  input  logic [DEPTH-1:0][IDX_W-1:0] i_age,
`endif
  output logic [DEPTH-1:0]            o_grant,
  output logic [IDX_W-1:0]            o_idx,
  output logic                        o_any
);

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0] w_best_age;

  // Oldest requesting entry
  always_comb begin
    o_grant    = '0;
    o_idx      = '0;
    o_any      = 1'b0;
    w_best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_req[i] && (!o_any || (i_age[i] < w_best_age))) begin
        o_any      = 1'b1;
        o_idx      = IDX_W'(i);
        w_best_age = i_age[i];
      end
    end
    o_grant[o_idx] = o_any;
  end
`else
  // Lowest-index requesting entry
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
    o_grant[o_idx] = o_any;
  end
`endif

endmodule

// File: rtl/resv_station.sv
// Reservation station: allocates issued ops into free entries, wakes
// waiting sources from the CDB, and dispatches one ready entry per cycle.
// Optional macro RS_AGE_ORDER_EN: dispatch oldest ready entry instead of
// lowest index (adds a per-entry age rank).
module resv_station
  import resv_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input logic   clk,
  input logic   rst_n,
  resv_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_rdy1;
  logic [DEPTH-1:0]  r_rdy2;
  logic [OP_W-1:0]   r_op   [DEPTH];
  logic [TAG_W-1:0]  r_dest [DEPTH];
  logic [DATA_W-1:0] r_val1 [DEPTH];
  logic [DATA_W-1:0] r_val2 [DEPTH];
  logic [TAG_W-1:0]  r_tag1 [DEPTH];
  logic [TAG_W-1:0]  r_tag2 [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic              r_hold;
  logic [IDX_W-1:0]  r_hold_idx;

  logic [DEPTH-1:0]  w_req;
  logic [DEPTH-1:0]  w_grant;
  logic [IDX_W-1:0]  w_idx;
  logic              w_any;
  logic              w_valid;
  logic [IDX_W-1:0]  w_sel;
  logic              w_alloc_ready;
  logic              w_alloc_fire;
  logic              w_disp_fire;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_src1_hit;
  logic              w_src2_hit;
  logic [DEPTH-1:0]  w_wake1;
  logic [DEPTH-1:0]  w_wake2;

  assign w_req = r_busy & r_rdy1 & r_rdy2;

`ifdef RS_AGE_ORDER_EN
  // Rank 0 = oldest busy entry; ranks stay dense as entries leave.
  logic [DEPTH-1:0][IDX_W-1:0] r_age;

  resv_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sel (
    .i_req   (w_req),
    .i_age   (r_age),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );
`else
  resv_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sel (
    .i_req   (w_req),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );
`endif

  // A presented-but-stalled entry stays selected so disp_* hold steady.
  assign w_valid       = r_hold | w_any;
  assign w_sel         = r_hold ? r_hold_idx : w_idx;
  assign w_alloc_ready = (r_count < CNT_W'(DEPTH));
  assign w_alloc_fire  = bus.alloc_valid && w_alloc_ready && !bus.flush;
  assign w_disp_fire   = w_valid && bus.disp_ready && !bus.flush;
  assign w_src1_hit    = bus.cdb_valid && (bus.cdb_tag == bus.src1_tag);
  assign w_src2_hit    = bus.cdb_valid && (bus.cdb_tag == bus.src2_tag);

  // Lowest free slot, from registered busy bits only
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
    end
  end

  // Per-entry CDB tag match for sources still waiting
  always_comb begin
    w_wake1 = '0;
    w_wake2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wake1[i] = bus.cdb_valid && r_busy[i] && !r_rdy1[i] && (r_tag1[i] == bus.cdb_tag);
      w_wake2[i] = bus.cdb_valid && r_busy[i] && !r_rdy2[i] && (r_tag2[i] == bus.cdb_tag);
    end
  end

  // Control state: busy/ready flags, occupancy, dispatch hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_rdy1     <= '0;
      r_rdy2     <= '0;
      r_count    <= '0;
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
    end else if (bus.flush) begin
      r_busy     <= '0;
      r_rdy1     <= '0;
      r_rdy2     <= '0;
      r_count    <= '0;
      r_hold     <= 1'b0;
    end else begin
      r_rdy1     <= r_rdy1 | w_wake1;
      r_rdy2     <= r_rdy2 | w_wake2;
      r_hold     <= w_valid && !bus.disp_ready;
      r_hold_idx <= w_sel;
      if (w_disp_fire) begin
        r_busy[w_sel] <= 1'b0;
        r_rdy1[w_sel] <= 1'b0;
        r_rdy2[w_sel] <= 1'b0;
      end
      if (w_alloc_fire) begin
        r_busy[w_free_idx] <= 1'b1;
        r_rdy1[w_free_idx] <= bus.src1_rdy | w_src1_hit;
        r_rdy2[w_free_idx] <= bus.src2_rdy | w_src2_hit;
      end
      r_count <= r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_disp_fire);
    end
  end

`ifdef RS_AGE_ORDER_EN
  // Age ranks: new entry goes to the back, ranks behind a dispatch close up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (!bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_disp_fire && r_busy[i] && (r_age[i] > r_age[w_sel])) r_age[i] <= r_age[i] - 1'b1;
      end
      if (w_alloc_fire) r_age[w_free_idx] <= IDX_W'(r_count - CNT_W'(w_disp_fire));
    end
  end
`endif

  // Entry payload: written on allocation and on CDB capture, never reset
  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wake1[i]) r_val1[i] <= bus.cdb_data;
        if (w_wake2[i]) r_val2[i] <= bus.cdb_data;
      end
    end
    if (w_alloc_fire) begin
      r_op[w_free_idx]   <= bus.alloc_op;
      r_dest[w_free_idx] <= bus.alloc_dest;
      r_tag1[w_free_idx] <= bus.src1_tag;
      r_tag2[w_free_idx] <= bus.src2_tag;
      r_val1[w_free_idx] <= bus.src1_rdy ? bus.src1_val : bus.cdb_data;
      r_val2[w_free_idx] <= bus.src2_rdy ? bus.src2_val : bus.cdb_data;
    end
  end

  assign bus.alloc_ready = w_alloc_ready;
  assign bus.disp_valid  = w_valid;
  assign bus.disp_op     = w_valid ? r_op[w_sel]   : '0;
  assign bus.disp_a      = w_valid ? r_val1[w_sel] : '0;
  assign bus.disp_b      = w_valid ? r_val2[w_sel] : '0;
  assign bus.disp_dest   = w_valid ? r_dest[w_sel] : '0;
  assign bus.count       = r_count;

endmodule
